// File: rtl/pc_pkg.sv
// pc_pkg: shared types and default parameters for the program counter.
// Opcodes are produced by the priority decode inside pc_unit.
package pc_pkg;

  localparam int PC_WIDTH_DEF = 8;
  localparam int PC_STEP_DEF  = 1;
  localparam int PC_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_BR,
    PC_LOAD,
    PC_CALL,
    PC_RET
  } pc_op_e;

endpackage

// File: rtl/pc_stack.sv
// pc_stack: DEPTH x WIDTH LIFO holding return addresses.
// Push on full and pop on empty are ignored; the caller flags them.
module pc_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign full_o  = (ptr_q == PW'(DEPTH));
  assign empty_o = (ptr_q == '0);
  assign wr_idx  = AW'(ptr_q);
  assign rd_idx  = AW'(ptr_q - 1'b1);
  assign top_o   = mem_q[rd_idx];

  always_comb begin
    ptr_d = ptr_q;
    if (push_i && !full_o) begin
      ptr_d = ptr_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Contents are don't-care after reset, so storage has no reset.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[wr_idx] <= data_i;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage PC with increment, jump, branch and optional
// return stack (build with PC_STACK_EN to enable call/ret, ovf, unf).
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = PC_WIDTH_DEF,
  parameter int               STEP      = PC_STEP_DEF,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               DEPTH     = PC_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_addr,
  input  logic             br,
  input  logic [WIDTH-1:0] br_off,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic             wrap,
  output logic             ovf,
  output logic             unf
);

  pc_op_e           op;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH-1:0] inc_val, br_val;
  logic             carry;
  logic             call_act, ret_act;
  logic             push, pop;
  logic             stk_full, stk_empty;
  logic [WIDTH-1:0] stk_top;

  assign inc_sum = {1'b0, pc_q} + (WIDTH + 1)'(STEP);
  assign inc_val = inc_sum[WIDTH-1:0];
  assign carry   = inc_sum[WIDTH];
  assign br_val  = pc_q + br_off;

`ifdef PC_STACK_EN
  assign call_act = call;
  assign ret_act  = ret;

  pc_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (inc_val),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );
`else
  logic unused_stk;

  assign call_act   = 1'b0;
  assign ret_act    = 1'b0;
  assign stk_full   = 1'b0;
  assign stk_empty  = 1'b1;
  assign stk_top    = '0;
  assign unused_stk = ^{call, ret, push, pop};
`endif

  logic r_ret, r_call, r_load, r_br;

  assign r_ret  = en & ret_act;
  assign r_call = en & ~ret_act & call_act;
  assign r_load = en & ~ret_act & ~call_act & load;
  assign r_br   = en & ~ret_act & ~call_act & ~load & br;

  always_comb begin
    op = PC_INC;
    unique case (1'b1)
      !en:    op = PC_HOLD;
      r_ret:  op = PC_RET;
      r_call: op = PC_CALL;
      r_load: op = PC_LOAD;
      r_br:   op = PC_BR;
      default: op = PC_INC;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    push   = 1'b0;
    pop    = 1'b0;
    unique case (op)
      PC_INC: begin
        pc_d   = inc_val;
        wrap_d = carry;
      end
      PC_BR:   pc_d = br_val;
      PC_LOAD: pc_d = load_addr;
      PC_CALL: begin
        pc_d = load_addr;
        push = ~stk_full;
        if (stk_full) ovf_d = 1'b1;
      end
      PC_RET: begin
        // Underflowing ret falls back to a plain sequential fetch.
        if (stk_empty) begin
          pc_d   = inc_val;
          wrap_d = carry;
          unf_d  = 1'b1;
        end else begin
          pc_d = stk_top;
          pop  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_VEC;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign pc      = pc_q;
  assign pc_next = pc_d;
  assign wrap    = wrap_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed tests for pc_unit (WIDTH=8, STEP=1, DEPTH=4).
// Expectations follow PC_STACK_EN as seen by this compile.
module tb_pc_unit;

`ifdef PC_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, en, load, br, call, ret;
  logic [7:0] load_addr, br_off;
  logic [7:0] pc, pc_next;
  logic       wrap, ovf, unf;

  int tests = 0;
  int fails = 0;

  pc_unit #(
    .WIDTH     (8),
    .STEP      (1),
    .RESET_VEC (8'h00),
    .DEPTH     (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .load_addr (load_addr),
    .br        (br),
    .br_off    (br_off),
    .call      (call),
    .ret       (ret),
    .pc        (pc),
    .pc_next   (pc_next),
    .wrap      (wrap),
    .ovf       (ovf),
    .unf       (unf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req();
    load = 0; br = 0; call = 0; ret = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; en = 1; clr_req();
    load_addr = 8'h00; br_off = 8'h00;
    #2;
    tests++;
    if (pc !== 8'h00) begin
      fails++; $display("FAIL reset_pc got=%h exp=00", pc);
    end
    tests++;
    if ({wrap, ovf, unf} !== 3'b000) begin
      fails++; $display("FAIL reset_flags got=%b exp=000", {wrap, ovf, unf});
    end
    step(); step();
    tests++;
    if (pc !== 8'h00) begin
      fails++; $display("FAIL reset_hold got=%h exp=00", pc);
    end
    rst_n = 1;
  endtask

  task automatic test_increment();
    tests++;
    if (pc_next !== 8'h01) begin
      fails++; $display("FAIL inc_next got=%h exp=01", pc_next);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      tests++;
      if (pc !== 8'(i) || wrap !== 1'b0) begin
        fails++;
        $display("FAIL inc%0d got=%h/%b exp=%h/0", i, pc, wrap, 8'(i));
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc [4];
    logic       exp_w  [4];
    exp_pc = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    exp_w  = '{1'b0, 1'b0, 1'b1, 1'b0};
    load = 1; load_addr = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      step();
      load = 0;
      tests++;
      if (pc !== exp_pc[i] || wrap !== exp_w[i]) begin
        fails++;
        $display("FAIL wrap%0d got=%h/%b exp=%h/%b",
                 i, pc, wrap, exp_pc[i], exp_w[i]);
      end
      if (i == 1) begin
        tests++;
        if (pc_next !== 8'h00) begin
          fails++; $display("FAIL wrap_next got=%h exp=00", pc_next);
        end
      end
    end
  endtask

  task automatic test_branch();
    load = 1; load_addr = 8'h10; step();
    br = 1; br_off = 8'hF8; load_addr = 8'h33; step();
    tests++;
    if (pc !== 8'h33) begin
      fails++; $display("FAIL br_vs_load got=%h exp=33", pc);
    end
    br = 0; load_addr = 8'h10; step();
    load = 0; br = 1; step();
    tests++;
    if (pc !== 8'h08) begin
      fails++; $display("FAIL br_back got=%h exp=08", pc);
    end
    step();
    br = 0;
    tests++;
    if (pc !== 8'h00 || wrap !== 1'b0) begin
      fails++; $display("FAIL br_wrap got=%h/%b exp=00/0", pc, wrap);
    end
  endtask

  task automatic test_call_ret();
    load = 1; load_addr = 8'h20; step();
    call = 1; load_addr = 8'h40; step();
    tests++;
    if (pc !== 8'h40) begin
      fails++; $display("FAIL call1 got=%h exp=40", pc);
    end
    load_addr = 8'h50; step();
    tests++;
    if (pc !== 8'h50) begin
      fails++; $display("FAIL call2 got=%h exp=50", pc);
    end
    clr_req(); ret = 1; step();
    tests++;
    if (pc !== (STK ? 8'h41 : 8'h51)) begin
      fails++; $display("FAIL ret1 got=%h exp=%h", pc, STK ? 8'h41 : 8'h51);
    end
    step();
    ret = 0;
    tests++;
    if (pc !== (STK ? 8'h21 : 8'h52)) begin
      fails++; $display("FAIL ret2 got=%h exp=%h", pc, STK ? 8'h21 : 8'h52);
    end
    tests++;
    if ({ovf, unf} !== 2'b00) begin
      fails++; $display("FAIL callret_flags got=%b exp=00", {ovf, unf});
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_pop [4];
    exp_pop = '{8'h63, 8'h62, 8'h61, 8'h01};
    rst_n = 0; clr_req(); #2; rst_n = 1;
    call = 1; load = 1;
    for (int i = 0; i < 5; i++) begin
      load_addr = 8'(8'h60 + i);
      step();
      tests++;
      if (pc !== 8'(8'h60 + i) || ovf !== (STK && i == 4)) begin
        fails++;
        $display("FAIL call_full%0d got=%h/%b exp=%h/%b",
                 i, pc, ovf, 8'(8'h60 + i), STK && i == 4);
      end
    end
    clr_req(); ret = 1;
    for (int j = 0; j < 4; j++) begin
      step();
      tests++;
      if (pc !== (STK ? exp_pop[j] : 8'(8'h65 + j))) begin
        fails++;
        $display("FAIL pop%0d got=%h exp=%h", j, pc,
                 STK ? exp_pop[j] : 8'(8'h65 + j));
      end
    end
    step();
    ret = 0;
    tests++;
    if (pc !== (STK ? 8'h02 : 8'h69) || unf !== STK) begin
      fails++;
      $display("FAIL ret_empty got=%h/%b exp=%h/%b",
               pc, unf, STK ? 8'h02 : 8'h69, STK);
    end
    step(); step();
    tests++;
    if (ovf !== STK || unf !== STK) begin
      fails++; $display("FAIL sticky got=%b%b exp=%b%b", ovf, unf, STK, STK);
    end
  endtask

  task automatic test_stall();
    load = 1; load_addr = 8'hFF; step();
    load = 0; step();
    tests++;
    if (pc !== 8'h00 || wrap !== 1'b1) begin
      fails++; $display("FAIL stall_pre got=%h/%b exp=00/1", pc, wrap);
    end
    en = 0; load = 1; load_addr = 8'h77;
    #1;
    tests++;
    if (pc_next !== 8'h00) begin
      fails++; $display("FAIL stall_next got=%h exp=00", pc_next);
    end
    step(); step();
    tests++;
    if (pc !== 8'h00 || wrap !== 1'b0) begin
      fails++; $display("FAIL stall got=%h/%b exp=00/0", pc, wrap);
    end
    en = 1; load = 0;
  endtask

  task automatic test_reset_mid();
    load = 1; load_addr = 8'h30; step();
    call = 1; load_addr = 8'h90; step();
    clr_req();
    #2; rst_n = 0; #1;
    tests++;
    if (pc !== 8'h00 || {ovf, unf} !== 2'b00) begin
      fails++; $display("FAIL mid_reset got=%h/%b exp=00/00", pc, {ovf, unf});
    end
    step();
    tests++;
    if (pc !== 8'h00) begin
      fails++; $display("FAIL mid_hold got=%h exp=00", pc);
    end
    rst_n = 1; ret = 1; step();
    ret = 0;
    tests++;
    if (pc !== 8'h01 || unf !== STK) begin
      fails++; $display("FAIL stk_cleared got=%h/%b exp=01/%b", pc, unf, STK);
    end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_wrap();
    test_branch();
    test_call_ret();
    test_overflow();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
